d_ram_dma: RTL and testbench
============================

Name: d_ram_dma

Overview:
- Block-transfer initiator on the d_ram read/write ports: copies a byte block from one d_ram region to another, or fills a region with a constant.
- Sits between the CPU-side I/O register file, which supplies the start/params strobe, and the d_ram ports.
- Shares d_ram with the core through a per-cycle grant input (mem_gnt).
- Tolerates d_ram's one-cycle registered read latency and arbitrary grant stalls; sustains 1 byte/cycle when granted.

Parameters:
- addr_width, 11, d_ram address width; all address arithmetic is modulo 2^addr_width.
- data_width, 8, d_ram word width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill; latched on start.
- src_addr  in  addr_width  copy source base; latched on start.
- dst_addr  in  addr_width  destination base; latched on start.
- len  in  addr_width+1  byte count, 0..2^addr_width; latched on start.
- fill_val  in  data_width  fill byte; latched on start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- mem_gnt  in  1  d_ram access granted this cycle.
- ram_r_addr  out  addr_width  to d_ram r_addr.
- ram_r_en  out  1  to d_ram r_en.
- ram_dout  in  data_width  from d_ram dout; valid the cycle after ram_r_en.
- ram_w_addr  out  addr_width  to d_ram w_addr.
- ram_w_en  out  1  to d_ram w_en.
- ram_din  out  data_width  to d_ram din.

Behaviour:
- Reset:
  - State goes to IDLE; busy=0, done=0.
  - ram_r_en=0, ram_w_en=0; address and data outputs are 0.
  - Read/write counters, pending flag and hold register are cleared.
  - Reset mid-transfer aborts immediately. Writes already issued remain; no done pulse.
- States: IDLE, RUN.
- IDLE:
  - start=1 with len=0: done=1 the next cycle; stay IDLE; no RAM access.
  - start=1 with len>0: latch params; rd_ptr=src, wr_ptr=dst; reads_left=writes_left=len; enter RUN; busy=1 from the next cycle.
- RUN, copy mode:
  - ram_r_en = mem_gnt & (reads_left != 0); ram_r_addr = rd_ptr.
  - pending is set the cycle after a read.
  - ram_w_en = mem_gnt & pending; ram_w_addr = wr_ptr.
  - ram_din = ram_dout if the read was issued in the previous cycle (fresh), else hold.
  - hold captures ram_dout in every cycle where fresh=1.
  - A read and a write may occur in the same cycle.
  - Because reads issue only when granted and every granted cycle drains pending, at most one byte is ever outstanding.
- RUN, fill mode:
  - ram_r_en=0 always.
  - ram_w_en = mem_gnt & (writes_left != 0); ram_din = fill_val.
- Counters:
  - Each issued read: rd_ptr+1, reads_left-1.
  - Each issued write: wr_ptr+1, writes_left-1.
  - Pointers wrap from 2^addr_width-1 to 0.
- Completion:
  - When the last write issues, the next cycle has busy=0, done=1, state IDLE.
  - A new start is accepted in the done cycle.
- start during RUN is ignored; latched parameters are unaffected.
- mem_gnt=0 in RUN: no RAM enables; counters hold; a pending byte survives in hold.
- Latency with mem_gnt held at 1 (start sampled at edge of cycle 0):
  - Copy: reads in cycles 1..len, writes in cycles 2..len+1, done in cycle len+2.
  - Fill: writes in cycles 1..len, done in cycle len+1.
- Overlapping copy (dst within (src, src+len) modulo wrap):
  - Destination contents are unspecified.
  - Cycle count and done are still as defined.
  - Non-overlapping copies and dst=src are exact.

Test Plan:
- Copy, mem_gnt=1: preload 0x10..0x13 = AA,BB,CC,DD; src=0x10, dst=0x40, len=4. Expect reads cycles 1-4, writes cycles 2-5, done cycle 6; mem[0x40..0x43] = AA,BB,CC,DD; busy high cycles 1-5.
- Fill: dst=0x7FE, len=4, fill_val=0x5A. Expect writes to 0x7FE, 0x7FF, 0x000, 0x001 in cycles 1-4 (wrap); done cycle 5.
- Grant stalls: copy len=3 with mem_gnt = 1,0,0,1,0,1,1,... Expect no enables while gnt=0; correct bytes written from hold; exactly 3 writes; done the cycle after the last write.
- len=0 start -> done in cycle 1; busy never asserts; no ram_r_en/ram_w_en.
- start pulsed during RUN with different params -> ignored; original transfer completes unchanged.
- rst asserted in cycle 3 of a len=8 copy -> outputs 0 the next cycle; exactly the writes issued before reset appear in memory; no done; a fresh start afterwards works normally.

Source files
------------

// File: rtl/d_ram_dma.sv
// Block-transfer initiator on the d_ram ports: copies a byte block between
// regions or fills a region with a constant, sharing d_ram via mem_gnt.
module d_ram_dma #(
   parameter int addr_width = 11,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [addr_width-1:0] src_addr,
   input  logic [addr_width-1:0] dst_addr,
   input  logic [addr_width:0]   len,
   input  logic [data_width-1:0] fill_val,
   output logic                  busy,
   output logic                  done,
   input  logic                  mem_gnt,
   output logic [addr_width-1:0] ram_r_addr,
   output logic                  ram_r_en,
   input  logic [data_width-1:0] ram_dout,
   output logic [addr_width-1:0] ram_w_addr,
   output logic                  ram_w_en,
   output logic [data_width-1:0] ram_din
);
   typedef enum logic {IDLE, RUN} state_t;

   typedef struct packed {
      logic                  fill;
      logic [data_width-1:0] val;
   } params_t;

   localparam logic [addr_width-1:0] PTR_ONE = 1;
   localparam logic [addr_width:0]   CNT_ONE = 1;

   state_t                state;
   params_t               prm;
   logic [addr_width-1:0] rd_ptr, wr_ptr;
   logic [addr_width:0]   reads_left, writes_left;
   logic                  pending, fresh;
   logic [data_width-1:0] hold;
   logic                  run;

   assign run  = (state == RUN);
   assign busy = run;

   // Enables follow the grant combinationally so a granted cycle is never wasted.
   always_comb begin
      ram_r_en   = run & ~prm.fill & mem_gnt & (reads_left != '0);
      ram_w_en   = run & mem_gnt & (prm.fill ? (writes_left != '0) : pending);
      ram_r_addr = rd_ptr;
      ram_w_addr = wr_ptr;
      ram_din    = prm.fill ? prm.val : (fresh ? ram_dout : hold);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done        <= 1'b0;
         prm         <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         reads_left  <= '0;
         writes_left <= '0;
         pending     <= 1'b0;
         fresh       <= 1'b0;
         hold        <= '0;
      end else begin
         done  <= 1'b0;
         fresh <= ram_r_en;
         if (fresh) hold <= ram_dout;
         if (ram_r_en) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            reads_left <= reads_left - CNT_ONE;
         end
         if (ram_w_en) begin
            wr_ptr      <= wr_ptr + PTR_ONE;
            writes_left <= writes_left - CNT_ONE;
         end
         // At most one byte outstanding: a granted cycle always drains pending.
         pending <= (pending & ~ram_w_en) | ram_r_en;
         case (state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     done <= 1'b1;
                  end else begin
                     prm.fill    <= mode;
                     prm.val     <= fill_val;
                     rd_ptr      <= src_addr;
                     wr_ptr      <= dst_addr;
                     reads_left  <= len;
                     writes_left <= len;
                     pending     <= 1'b0;
                     state       <= RUN;
                  end
               end
            end
            RUN: begin
               if (ram_w_en && writes_left == CNT_ONE) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_d_ram_dma.sv
// Directed bench for d_ram_dma with a registered-read d_ram model.
module tb_d_ram_dma;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [10:0] src_addr = '0;
   logic [10:0] dst_addr = '0;
   logic [11:0] len = '0;
   logic [7:0]  fill_val = '0;
   logic        busy, done;
   logic        mem_gnt = 1'b1;
   logic [10:0] ram_r_addr, ram_w_addr;
   logic        ram_r_en, ram_w_en;
   logic [7:0]  ram_dout = '0;
   logic [7:0]  ram_din;

   logic [7:0]  mem [2048];
   int checks = 0;
   int errors = 0;

   d_ram_dma #(.addr_width(11), .data_width(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
      .busy(busy), .done(done), .mem_gnt(mem_gnt),
      .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en), .ram_dout(ram_dout),
      .ram_w_addr(ram_w_addr), .ram_w_en(ram_w_en), .ram_din(ram_din)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_r_en) ram_dout <= mem[ram_r_addr];
      if (ram_w_en) mem[ram_w_addr] <= ram_din;
   end

   // Advance to the next cycle; inputs change 1 after the edge, sampling 2 after.
   task automatic next_cycle();
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic issue(input logic m, input logic [10:0] s, input logic [10:0] d,
                        input logic [11:0] l, input logic [7:0] f);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({busy, done, ram_r_en, ram_w_en} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctl: got %b need 0000", {busy, done, ram_r_en, ram_w_en});
      end
      checks++;
      if ({ram_r_addr, ram_w_addr, ram_din} !== 30'h0) begin
         errors++; $display("FAIL reset_bus: got %h/%h/%h need 0", ram_r_addr, ram_w_addr, ram_din);
      end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_copy();
      logic [7:0] d [4];
      logic [3:0] exp;
      d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC; d[3] = 8'hDD;
      for (int i = 0; i < 4; i++) begin mem[11'h10 + i] = d[i]; mem[11'h40 + i] = 8'h00; end
      next_cycle(); mem_gnt = 1'b1;
      issue(1'b0, 11'h10, 11'h40, 12'd4, 8'h00);
      for (int k = 1; k <= 6; k++) begin
         next_cycle(); #1;
         exp = {(k <= 5), (k == 6), (k <= 4), (k >= 2 && k <= 5)};
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== exp) begin
            errors++; $display("FAIL copy_ctl cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, exp);
         end
         if (ram_r_en) begin
            checks++;
            if (ram_r_addr !== 11'(16 + k - 1)) begin
               errors++; $display("FAIL copy_raddr cyc%0d: got %h need %h", k, ram_r_addr, 11'(16 + k - 1));
            end
         end
         if (ram_w_en) begin
            checks++;
            if ({ram_w_addr, ram_din} !== {11'(64 + k - 2), d[k-2]}) begin
               errors++; $display("FAIL copy_write cyc%0d: got %h/%h need %h/%h", k, ram_w_addr, ram_din, 11'(64 + k - 2), d[k-2]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[11'h40 + i] !== d[i]) begin
            errors++; $display("FAIL copy_mem[%0d]: got %h need %h", i, mem[11'h40 + i], d[i]);
         end
      end
   endtask

   task automatic test_fill();
      logic [3:0]  exp;
      logic [10:0] wa [4];
      wa[0] = 11'h7FE; wa[1] = 11'h7FF; wa[2] = 11'h000; wa[3] = 11'h001;
      issue(1'b1, 11'h123, 11'h7FE, 12'd4, 8'h5A);
      for (int k = 1; k <= 5; k++) begin
         next_cycle(); #1;
         exp = {(k <= 4), (k == 5), 1'b0, (k <= 4)};
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== exp) begin
            errors++; $display("FAIL fill_ctl cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, exp);
         end
         if (ram_w_en) begin
            checks++;
            if ({ram_w_addr, ram_din} !== {wa[k-1], 8'h5A}) begin
               errors++; $display("FAIL fill_write cyc%0d: got %h/%h need %h/5a", k, ram_w_addr, ram_din, wa[k-1]);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[wa[i]] !== 8'h5A) begin
            errors++; $display("FAIL fill_mem[%h]: got %h need 5a", wa[i], mem[wa[i]]);
         end
      end
   endtask

   task automatic test_stall();
      logic [8:1] g, er, ew, eb, ed;
      logic [7:0] d [3];
      int wi;
      g  = 8'b11101001; er = 8'b00101001; ew = 8'b01101000;
      eb = 8'b01111111; ed = 8'b10000000;
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      for (int i = 0; i < 3; i++) begin mem[11'h100 + i] = d[i]; mem[11'h200 + i] = 8'h00; end
      wi = 0;
      issue(1'b0, 11'h100, 11'h200, 12'd3, 8'h00);
      for (int k = 1; k <= 8; k++) begin
         next_cycle(); mem_gnt = g[k]; #1;
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== {eb[k], ed[k], er[k], ew[k]}) begin
            errors++; $display("FAIL stall_ctl cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, {eb[k], ed[k], er[k], ew[k]});
         end
         if (ram_w_en && wi < 3) begin
            checks++;
            if ({ram_w_addr, ram_din} !== {11'(12'h200 + wi), d[wi]}) begin
               errors++; $display("FAIL stall_write %0d: got %h/%h need %h/%h", wi, ram_w_addr, ram_din, 11'(12'h200 + wi), d[wi]);
            end
            wi++;
         end
      end
      mem_gnt = 1'b1;
      checks++;
      if (wi != 3) begin errors++; $display("FAIL stall_wcount: got %0d need 3", wi); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[11'h200 + i] !== d[i]) begin
            errors++; $display("FAIL stall_mem[%0d]: got %h need %h", i, mem[11'h200 + i], d[i]);
         end
      end
   endtask

   task automatic test_len0();
      next_cycle();
      issue(1'b0, 11'h10, 11'h50, 12'd0, 8'h00);
      next_cycle(); #1;
      checks++;
      if ({busy, done, ram_r_en, ram_w_en} !== 4'b0100) begin
         errors++; $display("FAIL len0_done: got %b need 0100", {busy, done, ram_r_en, ram_w_en});
      end
      next_cycle(); #1;
      checks++;
      if ({busy, done, ram_r_en, ram_w_en} !== 4'b0000) begin
         errors++; $display("FAIL len0_after: got %b need 0000", {busy, done, ram_r_en, ram_w_en});
      end
   endtask

   task automatic test_start_in_run();
      logic [3:0] exp;
      for (int i = 0; i < 3; i++) begin mem[11'h300 + i] = 8'hC0 + 8'(i); mem[11'h380 + i] = 8'h00; end
      mem[11'h500] = 8'h00;
      issue(1'b0, 11'h300, 11'h380, 12'd3, 8'h00);
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         if (k == 2) issue(1'b1, 11'h010, 11'h500, 12'd5, 8'hEE);
         #1;
         exp = {(k <= 4), (k == 5), (k <= 3), (k >= 2 && k <= 4)};
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== exp) begin
            errors++; $display("FAIL ign_ctl cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, exp);
         end
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (mem[11'h380 + i] !== 8'hC0 + 8'(i)) begin
            errors++; $display("FAIL ign_mem[%0d]: got %h need %h", i, mem[11'h380 + i], 8'hC0 + 8'(i));
         end
      end
      checks++;
      if (mem[11'h500] !== 8'h00) begin errors++; $display("FAIL ign_stray: got %h need 00", mem[11'h500]); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp;
      next_cycle();
      issue(1'b1, 11'h000, 11'h600, 12'd2, 8'h77);
      for (int k = 1; k <= 5; k++) begin
         next_cycle();
         if (k == 3) issue(1'b1, 11'h000, 11'h610, 12'd1, 8'h88);
         #1;
         exp = {(k <= 2 || k == 4), (k == 3 || k == 5), 1'b0, (k <= 2 || k == 4)};
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== exp) begin
            errors++; $display("FAIL b2b_ctl cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, exp);
         end
      end
      checks++;
      if ({mem[11'h600], mem[11'h601], mem[11'h610]} !== 24'h777788) begin
         errors++; $display("FAIL b2b_mem: got %h%h%h need 777788", mem[11'h600], mem[11'h601], mem[11'h610]);
      end
   endtask

   task automatic test_rst_mid();
      logic [3:0] exp;
      for (int i = 0; i < 8; i++) begin
         mem[11'h020 + i] = 8'h90 + 8'(i); mem[11'h700 + i] = 8'h00; mem[11'h720 + i] = 8'h00;
      end
      next_cycle();
      issue(1'b0, 11'h020, 11'h700, 12'd8, 8'h00);
      next_cycle(); next_cycle();
      next_cycle(); rst = 1'b1;
      next_cycle(); rst = 1'b0; #1;
      checks++;
      if ({busy, done, ram_r_en, ram_w_en, ram_r_addr, ram_w_addr, ram_din} !== 34'h0) begin
         errors++; $display("FAIL rstmid_out: got %b %h %h %h need zeros", {busy, done, ram_r_en, ram_w_en}, ram_r_addr, ram_w_addr, ram_din);
      end
      for (int k = 0; k < 6; k++) begin
         next_cycle(); #1;
         checks++;
         if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL rstmid_idle %0d: got %b need 00", k, {busy, done});
         end
      end
      checks++;
      if (mem[11'h700] !== 8'h90) begin errors++; $display("FAIL rstmid_first: got %h need 90", mem[11'h700]); end
      for (int i = 2; i < 8; i++) begin
         checks++;
         if (mem[11'h700 + i] !== 8'h00) begin
            errors++; $display("FAIL rstmid_extra[%0d]: got %h need 00", i, mem[11'h700 + i]);
         end
      end
      issue(1'b0, 11'h020, 11'h720, 12'd2, 8'h00);
      for (int k = 1; k <= 4; k++) begin
         next_cycle(); #1;
         exp = {(k <= 3), (k == 4), (k <= 2), (k >= 2 && k <= 3)};
         checks++;
         if ({busy, done, ram_r_en, ram_w_en} !== exp) begin
            errors++; $display("FAIL rstmid_again cyc%0d: got %b need %b", k, {busy, done, ram_r_en, ram_w_en}, exp);
         end
      end
      checks++;
      if ({mem[11'h720], mem[11'h721]} !== 16'h9091) begin
         errors++; $display("FAIL rstmid_again_mem: got %h%h need 9091", mem[11'h720], mem[11'h721]);
      end
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
      test_reset();
      test_copy();
      test_fill();
      test_stall();
      test_len0();
      test_start_in_run();
      test_back_to_back();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
